requant_relu_pool2: RTL and testbench

Downstream stage of the 3x3 convolution engine in the first-layer stream pipeline. Consumes the signed wide accumulator stream (one valid result per window), adds a per-channel bias, applies ReLU, rounds and right-shifts to 8-bit unsigned activations, and performs 2x2 stride-2 max pooling. Its output stream feeds the next layer's convolution input directly.

---
 rtl/requant_relu_pool2_pkg.sv | 9 +
 rtl/requant_relu.sv | 32 +++
 rtl/requant_relu_pool2.sv | 66 ++++++
 tb/tb_requant_relu_pool2.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/requant_relu_pool2_pkg.sv
// requant_relu_pool2_pkg: shared widths, saturation constant and rounding helper
package requant_relu_pool2_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF = 24;
  localparam int SAT_MAX = (1 << DATA_W_DEF) - 1;
  function automatic logic [47:0] round_shr(input logic [47:0] v, input logic [4:0] sh);
    return (v + ((sh != 5'd0) ? (48'd1 << (sh - 5'd1)) : 48'd0)) >> sh;
  endfunction
endpackage

// File: rtl/requant_relu.sv
// requant_relu: bias add, ReLU, round-half-up shift and saturation, registered
module requant_relu
  import requant_relu_pool2_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ACC_W-1:0]  in_data,
  input  logic [ACC_W-1:0]  bias,
  input  logic [4:0]        shift,
  output logic [DATA_W-1:0] q,
  output logic              q_valid
);
  logic [ACC_W:0] s;
  logic [47:0] r;
  always_comb begin
    s = {in_data[ACC_W-1], in_data} + {bias[ACC_W-1], bias};
    r = round_shr(48'(s), shift);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= in_valid;
      if (in_valid) q <= s[ACC_W] ? '0 : (|r[47:DATA_W] ? '1 : r[DATA_W-1:0]);
    end
  end
endmodule

// File: rtl/requant_relu_pool2.sv
// requant_relu_pool2: requantised activations followed by 2x2 stride-2 max pooling
module requant_relu_pool2
  import requant_relu_pool2_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int MAX_WIDTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ACC_W-1:0]  in_data,
  input  logic [ACC_W-1:0]  bias,
  input  logic [4:0]        shift,
  input  logic [15:0]       fmap_width,
  input  logic [15:0]       fmap_height,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pixel,
  output logic              frame_done
);
  localparam int AW = $clog2(MAX_WIDTH / 2);
  logic [DATA_W-1:0] q, pend, h, lb, m;
  logic q_valid, last_col, last_row;
  logic [15:0] col, row;
  logic [DATA_W-1:0] linebuf [MAX_WIDTH/2];
  requant_relu #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_rq (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .bias(bias), .shift(shift), .q(q), .q_valid(q_valid)
  );
  always_comb begin
    h = (pend > q) ? pend : q;
    lb = linebuf[col[AW:1]];
    m = (h > lb) ? h : lb;
    last_col = (col == fmap_width - 16'd1);
    last_row = (row == fmap_height - 16'd1);
  end
  // Line buffer is written on even rows before any odd-row read, so it needs no reset.
  always_ff @(posedge clk) begin
    if (q_valid && col[0] && !row[0]) linebuf[col[AW:1]] <= h;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      frame_done <= 1'b0;
      pend <= '0;
      col <= '0;
      row <= '0;
    end else begin
      out_valid <= 1'b0;
      frame_done <= 1'b0;
      if (q_valid) begin
        if (!col[0]) pend <= q;
        else if (row[0]) begin
          out_pixel <= m;
          out_valid <= 1'b1;
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 16'd1;
          frame_done <= last_row;
        end else col <= col + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_requant_relu_pool2.sv
// tb_requant_relu_pool2: directed frames checked against a frame-level pooling model
module tb_requant_relu_pool2;
  typedef struct {longint v; int idx;} exp_t;
  logic clk = 0, rst = 1, in_valid = 0, out_valid, frame_done;
  logic [23:0] in_data = '0, bias = '0;
  logic [4:0] shift = '0;
  logic [15:0] fmap_width = 16'd4, fmap_height = 16'd4;
  logic [7:0] out_pixel;
  int checks = 0, failures = 0, cyc = 0, gidx = 0;
  int drv_cyc [1024];
  longint fr [256];
  exp_t eq [$];
  int fq [$];
  exp_t e;
  int fi;

  requant_relu_pool2 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .bias(bias),
    .shift(shift), .fmap_width(fmap_width), .fmap_height(fmap_height),
    .out_valid(out_valid), .out_pixel(out_pixel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic longint rq(input longint d, input longint b, input int sh);
    longint s, r;
    s = d + b;
    if (s < 0) return 0;
    r = (s + (sh > 0 ? (longint'(1) << (sh - 1)) : 0)) >> sh;
    return r > 255 ? 255 : r;
  endfunction

  function automatic longint pool_val(input int w, input int i, input int j, input longint b, input int sh);
    longint mx = 0;
    for (int di = 0; di < 2; di++)
      for (int dj = 0; dj < 2; dj++)
        if (rq(fr[(2*i+di)*w + 2*j+dj], b, sh) > mx) mx = rq(fr[(2*i+di)*w + 2*j+dj], b, sh);
    return mx;
  endfunction

  task automatic send(input longint d);
    longint t;
    t = d;
    in_valid = 1;
    in_data = t[23:0];
    drv_cyc[gidx] = cyc;
    gidx++;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic run_frame(input int w, input int h, input longint b, input int sh, input int gap);
    int base;
    longint bb;
    bb = b;
    bias = bb[23:0];
    shift = 5'(sh);
    fmap_width = 16'(w);
    fmap_height = 16'(h);
    base = gidx;
    for (int i = 0; i < h/2; i++)
      for (int j = 0; j < w/2; j++)
        eq.push_back('{pool_val(w, i, j, b, sh), base + (2*i+1)*w + 2*j+1});
    fq.push_back(base + w*h - 1);
    for (int k = 0; k < w*h; k++) begin
      send(fr[k]);
      repeat (gap) @(negedge clk);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic uniform_frame(input longint v, input longint b, input int sh);
    for (int k = 0; k < 4; k++) fr[k] = v;
    run_frame(2, 2, b, sh, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (eq.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          e = eq.pop_front();
          chk("out_pixel", out_pixel, e.v);
          chk("out_latency", cyc, drv_cyc[e.idx] + 2);
        end
      end
      if (frame_done) begin
        if (fq.size() == 0) chk("unexpected_frame_done", 1, 0);
        else begin
          fi = fq.pop_front();
          chk("frame_done_cycle", cyc, drv_cyc[fi] + 2);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    chk("model_rq7", rq(7, 0, 4), 0);
    chk("model_rq8", rq(8, 0, 4), 1);
    chk("model_rq24", rq(24, 0, 4), 2);
    chk("model_rqneg", rq(-5, 0, 4), 0);
    chk("model_rqsat", rq(100000, 0, 4), 255);
    chk("model_relu99", rq(99, -100, 0), 0);
    chk("model_bias150", rq(150, -100, 0), 50);
    for (int k = 0; k < 16; k++) fr[k] = k + 1;
    chk("model_pool00", pool_val(4, 0, 0, 0, 0), 6);
    chk("model_pool01", pool_val(4, 0, 1, 0, 0), 8);
    chk("model_pool10", pool_val(4, 1, 0, 0, 0), 14);
    chk("model_pool11", pool_val(4, 1, 1, 0, 0), 16);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pixel", out_pixel, 0);
    chk("rst_frame_done", frame_done, 0);
    rst = 0;
    @(negedge clk);
    uniform_frame(7, 0, 4);
    uniform_frame(8, 0, 4);
    uniform_frame(24, 0, 4);
    uniform_frame(-5, 0, 4);
    uniform_frame(100000, 0, 4);
    uniform_frame(99, -100, 0);
    uniform_frame(150, -100, 0);
    for (int k = 0; k < 16; k++) fr[k] = k + 1;
    run_frame(4, 4, 0, 0, 0);
    for (int k = 0; k < 15; k++) fr[k] = k;
    run_frame(5, 3, 0, 0, 0);
    for (int k = 0; k < 16; k++) fr[k] = k + 1;
    run_frame(4, 4, 0, 0, 1);
    fr[0] = 9;
    run_frame(1, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) fr[k] = 200;
    run_frame(3, 1, 0, 0, 0);
    fmap_width = 16'd4;
    fmap_height = 16'd4;
    for (int k = 0; k < 6; k++) send(100 + k);
    rst = 1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_pixel", out_pixel, 0);
    chk("midrst_frame_done", frame_done, 0);
    rst = 0;
    @(negedge clk);
    chk("postrst_out_valid", out_valid, 0);
    chk("postrst_out_pixel", out_pixel, 0);
    for (int k = 0; k < 16; k++) fr[k] = k + 1;
    run_frame(4, 4, 0, 0, 0);
    repeat (10) @(negedge clk);
    chk("pending_outputs", eq.size(), 0);
    chk("pending_frame_done", fq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
